param_regfile_display: RTL and testbench

PARAM_REGFILE_DISPLAY -- requirements
Module: param_regfile_display

---
 rtl/param_regfile_pkg.sv | 33 +++
 rtl/debounce_pulse.sv | 56 +++++
 rtl/param_regfile_display.sv | 101 ++++++++++
 tb/tb_param_regfile_display.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_regfile_pkg.sv
// Shared display helpers for the debounced register-file demo:
// anode idle pattern and hex-to-7-segment glyph lookup.
`timescale 1ns/1ps
package param_regfile_pkg;

    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = 7'b1111111;
        unique case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Turns a bouncing push-button into a single-cycle strobe: synchroniser,
// sample-tick divider, stability counter and rising-edge detector.
`timescale 1ns/1ps
module debounce_pulse #(
    parameter int unsigned DB_DIV = 100000,
    parameter int unsigned DB_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned TICK_W = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam int unsigned CNT_W  = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

    logic [TICK_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0]  db_cnt_q;
    logic              sync1_q;
    logic              sync2_q;
    logic              level_q;
    logic              level_prev_q;
    logic              tick;

    assign tick = (tick_cnt_q == TICK_W'(DB_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            db_cnt_q     <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            tick_cnt_q   <= tick ? '0 : tick_cnt_q + 1'b1;
            // Any sample agreeing with the current level restarts the run.
            if (tick) begin
                if (sync2_q == level_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == CNT_W'(DB_CNT - 1)) begin
                    level_q  <= sync2_q;
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 1'b1;
                end
            end
        end
    end

    assign pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/param_regfile_display.sv
// Register file written by a debounced button, with two combinational read
// ports shown in hex on a multiplexed 8-digit seven-segment display.
`timescale 1ns/1ps
module param_regfile_display
    import param_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned DB_DIV   = 100000,
    parameter int unsigned DB_CNT   = 4,
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] W,
    input  logic [ADDR_W-1:0] W_Adr,
    input  logic [ADDR_W-1:0] R_Adr,
    input  logic [ADDR_W-1:0] S_Adr,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S,
    output logic              we_pulse,
    output logic [7:0]        an,
    output logic [6:0]        seg
);

    localparam int unsigned ND     = DATA_W / 2;
    localparam int unsigned DIG_W  = $clog2(ND);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [SCAN_W-1:0]   scan_cnt_q;
    logic [DIG_W-1:0]    digit_q;
    logic [7:0]          an_q;
    logic [6:0]          seg_q;
    logic [2*DATA_W-1:0] disp;
    logic [3:0]          nibble;
    logic                scan_wrap;

    debounce_pulse #(
        .DB_DIV (DB_DIV),
        .DB_CNT (DB_CNT)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (we),
        .pulse (we_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_pulse && !(ZERO_REG && (W_Adr == '0))) begin
            regs_q[W_Adr] <= W;
        end
    end

    always_comb begin
        R = regs_q[R_Adr];
        S = regs_q[S_Adr];
        if (BYPASS && we_pulse) begin
            if (R_Adr == W_Adr) R = W;
            if (S_Adr == W_Adr) S = W;
        end
        // Hard zero wins over the bypass path.
        if (ZERO_REG) begin
            if (R_Adr == '0) R = '0;
            if (S_Adr == '0) S = '0;
        end
    end

    // Low digits carry R, high digits carry S, least-significant nibble first.
    assign disp      = {S, R};
    assign nibble    = disp[{digit_q, 2'b00} +: 4];
    assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
            an_q       <= {AN_ALL_OFF[7:1], 1'b0};
            seg_q      <= hex_to_seg(4'h0);
        end else begin
            scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
            if (scan_wrap) begin
                digit_q <= (digit_q == DIG_W'(ND - 1)) ? '0 : digit_q + 1'b1;
            end
            an_q  <= AN_ALL_OFF & ~(8'd1 << digit_q);
            seg_q <= hex_to_seg(nibble);
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_param_regfile_display.sv
// Self-checking bench: two instances (bypass + hard zero, and plain) share
// stimulus; writes go through a scoreboard queue, reads via a vector table.
`timescale 1ns/1ps
module tb_param_regfile_display;

    typedef struct {
        logic [2:0] adr;
        logic [3:0] data;
    } wr_t;

    typedef struct {
        logic [3:0] r_a;
        logic [3:0] s_a;
        logic [3:0] r_b;
        logic [3:0] s_b;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       we = 1'b0;
    logic [3:0] W = '0;
    logic [2:0] W_Adr = '0;
    logic [2:0] R_Adr = '0;
    logic [2:0] S_Adr = '0;
    logic [3:0] r_a, s_a, r_b, s_b;
    logic       wp_a, wp_b;
    logic [7:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;

    int checks = 0;
    int errors = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    int exp_pulses = 0;

    logic [3:0] model_a [8];
    logic [3:0] model_b [8];
    logic [6:0] glyph [16];
    wr_t        wr_q [$];
    rd_exp_t    rd_q [$];
    wr_t        wr_tab [6];

    param_regfile_display #(
        .DATA_W(4), .DEPTH(8), .DB_DIV(2), .DB_CNT(3), .SCAN_DIV(4),
        .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .we(we), .W(W), .W_Adr(W_Adr), .R_Adr(R_Adr),
        .S_Adr(S_Adr), .R(r_a), .S(s_a), .we_pulse(wp_a), .an(an_a), .seg(seg_a)
    );

    param_regfile_display #(
        .DATA_W(4), .DEPTH(8), .DB_DIV(2), .DB_CNT(3), .SCAN_DIV(4),
        .BYPASS(1'b0), .ZERO_REG(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .we(we), .W(W), .W_Adr(W_Adr), .R_Adr(R_Adr),
        .S_Adr(S_Adr), .R(r_b), .S(s_b), .we_pulse(wp_b), .an(an_b), .seg(seg_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset !== 1'b1 && wp_a === 1'b1) pulses_a++;
        if (reset !== 1'b1 && wp_b === 1'b1) pulses_b++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 8; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
    endtask

    task automatic read_all(input string tag);
        rd_exp_t e;
        for (int i = 0; i < 8; i++) begin
            R_Adr = 3'(i);
            S_Adr = 3'(7 - i);
            rd_q.push_back('{model_a[i], model_a[7 - i], model_b[i], model_b[7 - i]});
            @(negedge clk);
            e = rd_q.pop_front();
            check({tag, " R dut_a"}, r_a, e.r_a);
            check({tag, " S dut_a"}, s_a, e.s_a);
            check({tag, " R dut_b"}, r_b, e.r_b);
            check({tag, " S dut_b"}, s_b, e.s_b);
        end
        tick(1);
    endtask

    // Bouncing press, hold, release; the scoreboard entry is retired on the strobe.
    task automatic press(input logic [2:0] adr, input logic [3:0] data);
        logic [9:0] pat;
        realtime    t_edge;
        bit         seen;
        int         lat;
        wr_t        tr;
        pat = 10'b1100110011;
        t_edge = 0;
        W = data;
        W_Adr = adr;
        R_Adr = adr;
        S_Adr = adr;
        wr_q.push_back('{adr, data});
        exp_pulses++;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            we = pat[i];
            if (i == 8) t_edge = $realtime;
        end
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick(1);
            if (wp_a === 1'b1) seen = 1'b1;
        end
        check("we_pulse seen before timeout", 32'(seen), 1);
        if (seen) begin
            tr = wr_q.pop_front();
            lat = int'(($realtime - t_edge) / 10.0);
            check("pulse latency 6..8", 32'(lat >= 6 && lat <= 8), 1);
            check("pulse dut_b", 32'(wp_b), 1);
            check("bypass R dut_a", r_a, (tr.adr == 3'd0) ? 4'h0 : tr.data);
            check("bypass S dut_a", s_a, (tr.adr == 3'd0) ? 4'h0 : tr.data);
            check("no-bypass S dut_b", s_b, model_b[tr.adr]);
            if (tr.adr != 3'd0) model_a[tr.adr] = tr.data;
            model_b[tr.adr] = tr.data;
            tick(1);
            check("pulse single cycle", 32'(wp_a), 0);
            check("written R dut_a", r_a, model_a[tr.adr]);
            check("written S dut_b", s_b, model_b[tr.adr]);
        end
        tick(25);
        we = 1'b0;
        tick(25);
        check("pulse count dut_a", pulses_a, exp_pulses);
        check("pulse count dut_b", pulses_b, exp_pulses);
    endtask

    initial begin
        int         run;
        int         runs_done;
        logic [7:0] prev_an;

        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
        glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
        glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
        glyph[15] = 7'b0001110;
        wr_tab = '{'{3'd3, 4'hA}, '{3'd5, 4'h7}, '{3'd0, 4'hF},
                   '{3'd1, 4'h1}, '{3'd2, 4'h2}, '{3'd7, 4'hC}};
        clear_models();

        reset = 1'b1;
        tick(3);
        check("reset an", an_a, 8'hFE);
        check("reset seg", seg_a, 7'b1000000);
        check("reset we_pulse", 32'(wp_a), 0);
        check("reset an dut_b", an_b, 8'hFE);
        check("reset R", r_a, 0);
        reset = 1'b0;
        tick(2);
        read_all("post-reset");

        for (int i = 0; i < 6; i++) begin
            press(wr_tab[i].adr, wr_tab[i].data);
            if (i == 0) read_all("after first write");
        end
        read_all("after table writes");

        // Display: R=1 on digit 0, S=2 on digit 1.
        R_Adr = 3'd1;
        S_Adr = 3'd2;
        tick(2);
        run = 0;
        runs_done = 0;
        prev_an = an_a;
        for (int c = 0; c < 48; c++) begin
            tick(1);
            check("an one of FE/FD", 32'(an_a == 8'hFE || an_a == 8'hFD), 1);
            check("seg glyph", seg_a,
                  (an_a == 8'hFD) ? glyph[model_a[2]] : glyph[model_a[1]]);
            if (an_a == prev_an) begin
                run++;
            end else begin
                if (runs_done > 0) check("scan dwell", run, 4);
                runs_done++;
                run = 1;
                prev_an = an_a;
            end
        end
        check("scan alternates", 32'(runs_done >= 10), 1);

        // Reset in the middle of a scan.
        for (int c = 0; c < 20 && an_a != 8'hFD; c++) tick(1);
        check("reached digit 1", an_a, 8'hFD);
        reset = 1'b1;
        #1;
        check("mid-scan reset an", an_a, 8'hFE);
        check("mid-scan reset seg", seg_a, 7'b1000000);
        check("mid-scan reset R dut_b", r_b, 0);
        clear_models();
        tick(3);
        reset = 1'b0;
        tick(2);
        read_all("after mid-scan reset");

        // Reset in the middle of a debounce: the aborted press must not write.
        W = 4'h9;
        W_Adr = 3'd4;
        we = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        we = 1'b0;
        reset = 1'b0;
        tick(30);
        check("aborted press pulses", pulses_a, exp_pulses);
        read_all("after aborted press");
        press(3'd4, 4'h9);
        read_all("after retried press");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
